// File: rtl/fp_pkg.sv
// Shared floating-point constants and the divider FSM state type.
// Defaults describe IEEE-754 double precision. EXP_MAX is the largest
// biased exponent (reserved for infinity). EXP_INF is that exponent as a field.
package fp_pkg;
  localparam int EXP_DEF  = 11;
  localparam int MANT_DEF = 52;
  localparam int BIAS_DEF = 1023;
  localparam int EXP_MAX  = (1 << EXP_DEF) - 1;
  localparam logic [EXP_DEF-1:0] EXP_INF = '1;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, ROUND, DONE} state_t;
endpackage

// File: rtl/fdiv_round.sv
// Combinational round-and-pack stage for the floating-point divider.
// Rounding is round-to-nearest-even.
//   q      in  MANT+2      quotient {integer bit, MANT fraction bits, guard}
//   sticky in  1           nonzero remainder beyond the guard bit
//   e      in  EXP+2 (s)   biased exponent before rounding
//   sign   in  1           result sign
//   word   out DATA_WIDTH  packed result. Overflow saturates to signed infinity.
//                          Underflow flushes to the all-zero word.
module fdiv_round
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int EXP        = EXP_DEF,
  parameter int MANT       = MANT_DEF
) (
  input  logic [MANT+1:0]        q,
  input  logic                   sticky,
  input  logic signed [EXP+1:0]  e,
  input  logic                   sign,
  output logic [DATA_WIDTH-1:0]  word
);
  localparam logic signed [EXP+1:0] E_MAX  = (EXP+2)'((1 << EXP) - 1);
  localparam logic signed [EXP+1:0] E_ZERO = '0;
  localparam logic signed [EXP+1:0] E_ONE  = (EXP+2)'(1);

  logic              inc;
  logic [MANT+1:0]   sig_r;
  logic signed [EXP+1:0] e_r;

  always_comb begin
    inc   = q[0] & (sticky | q[1]);
    // A carry out of the integer bit means 1.111..1 rounded up to 2.0.
    sig_r = {1'b0, q[MANT+1:1]} + {{(MANT+1){1'b0}}, inc};
    e_r   = sig_r[MANT+1] ? e + E_ONE : e;
    if (e_r >= E_MAX)
      word = {sign, {EXP{1'b1}}, {MANT{1'b0}}};
    else if (e_r <= E_ZERO)
      word = '0;
    else
      word = {sign, e_r[EXP-1:0], sig_r[MANT-1:0]};
  end
endmodule

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 divider c = a / b.
// It uses a radix-2 restoring mantissa divider that produces one quotient bit per cycle.
//   clk_i    in  1           clock, rising edge
//   rst_ni   in  1           asynchronous active-low reset
//   valid_i  in  1           a_i/b_i valid (only sampled while ready_o)
//   ready_o  out 1           divider idle and able to accept operands
//   a_i      in  DATA_WIDTH  dividend
//   b_i      in  DATA_WIDTH  divisor
//   valid_o  out 1           c_o holds a result, stable until ready_i
//   ready_i  in  1           consumer accepts c_o
//   c_o      out DATA_WIDTH  quotient {sign, exp, mant}
// Latency from the accept edge to valid_o is MANT+4 cycles.
module fdiv_seq
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int EXP        = EXP_DEF,
  parameter int MANT       = MANT_DEF,
  parameter int BIAS       = BIAS_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] c_o
);
  localparam int CNT_W = $clog2(MANT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [EXP+1:0]   BIAS_E   = (EXP+2)'(BIAS);
  localparam logic [EXP+1:0]   E_ONE    = (EXP+2)'(1);

  state_t                state;
  logic                  sign;
  logic                  a_zero;
  logic                  b_zero;
  logic [EXP-1:0]        ea;
  logic [EXP-1:0]        eb;
  logic [MANT+1:0]       rem;
  logic [MANT+1:0]       mb;
  logic [MANT+1:0]       q;
  logic [CNT_W-1:0]      cnt;
  logic signed [EXP+1:0] e;

  logic                  lt;
  logic [EXP+1:0]        e_base;
  logic signed [EXP+1:0] e_load;
  logic                  ge;
  logic [MANT+1:0]       rem_sub;
  logic [DATA_WIDTH-1:0] rounded;

  // Normalisation: when ma < mb the dividend is doubled so the quotient lands in [1,2).
  assign lt      = rem < mb;
  assign e_base  = {2'b00, ea} - {2'b00, eb} + BIAS_E;
  assign e_load  = lt ? $signed(e_base - E_ONE) : $signed(e_base);
  assign ge      = rem >= mb;
  assign rem_sub = ge ? rem - mb : rem;

  fdiv_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXP        (EXP),
    .MANT       (MANT)
  ) u_round (
    .q      (q),
    .sticky (rem != '0),
    .e      (e),
    .sign   (sign),
    .word   (rounded)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      c_o     <= '0;
      sign    <= 1'b0;
      a_zero  <= 1'b0;
      b_zero  <= 1'b0;
      ea      <= '0;
      eb      <= '0;
      rem     <= '0;
      mb      <= '0;
      q       <= '0;
      cnt     <= '0;
      e       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            sign    <= a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1];
            a_zero  <= (a_i == '0);
            b_zero  <= (b_i == '0);
            ea      <= a_i[DATA_WIDTH-2 -: EXP];
            eb      <= b_i[DATA_WIDTH-2 -: EXP];
            // The remainder register is loaded directly with the dividend mantissa.
            rem     <= {2'b01, a_i[MANT-1:0]};
            mb      <= {2'b01, b_i[MANT-1:0]};
            ready_o <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          e     <= e_load;
          if (lt) rem <= rem << 1;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          rem <= rem_sub << 1;
          q   <= {q[MANT:0], ge};
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= ROUND;
        end
        ROUND: begin
          // Specials still run the full iteration count. They override the result here.
          if (a_zero)
            c_o <= '0;
          else if (b_zero)
            c_o <= {sign, {EXP{1'b1}}, {MANT{1'b0}}};
          else
            c_o <= rounded;
          valid_o <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
